// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-write link: FSM states, frame layout
// and the peripheral's register map.
package spi_reg_pkg;

  localparam int unsigned FRAME_W    = 16;
  localparam logic        WRITE_FLAG = 1'b1;

  localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  // Over-the-wire write frame, MSB first.
  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_frame_t;

endpackage

// File: rtl/spi_half_period_tick.sv
// Half-period timebase: while enabled, pulses tick_c once every CLK_DIV cycles;
// pre_tick_c fires on the cycle before tick_c. Counter clears whenever disabled.
module spi_half_period_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_c,
  output logic pre_tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = '0;
    if (en && (div_cnt_q != CNT_W'(CLK_DIV - 1))) begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick_c     = en && (div_cnt_q == CNT_W'(CLK_DIV - 1));
  assign pre_tick_c = en && (div_cnt_q == CNT_W'(CLK_DIV - 2));

endmodule

// File: rtl/spi_reg_write_initiator.sv
// SPI mode-0 initiator that serialises one {1, addr, data} register-write frame
// per accepted command, followed by a fixed chip-select-high gap.
module spi_reg_write_initiator
  import spi_reg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              ncs,
  output logic              sclk,
  output logic              copi
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_reg_write_initiator: CLK_DIV must be >= 2");
  end
  if ((1 + ADDR_W + DATA_W) != FRAME_W) begin : g_bad_frame_w
    $error("spi_reg_write_initiator: 1+ADDR_W+DATA_W must equal FRAME_W");
  end

  localparam int unsigned EDGE_W = 5;

  spi_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic               gap_half_q, gap_half_d;
  logic               ncs_q, ncs_d;
  logic               sclk_q, sclk_d;
  logic               copi_q, copi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic tick_en_c;
  logic tick_c;
  logic pre_tick_c;

  assign tick_en_c = (state_q != IDLE);

  spi_half_period_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .en         (tick_en_c),
    .tick_c     (tick_c),
    .pre_tick_c (pre_tick_c)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    edge_cnt_d  = edge_cnt_q;
    gap_half_d  = gap_half_q;
    ncs_d       = ncs_q;
    sclk_d      = sclk_q;
    copi_d      = copi_q;
    cmd_ready_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          shift_d     = FRAME_W'({WRITE_FLAG, cmd_addr, cmd_data});
          edge_cnt_d  = '0;
          ncs_d       = 1'b0;
          sclk_d      = 1'b0;
          copi_d      = WRITE_FLAG;
          cmd_ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (tick_c) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
        end
      end
      SHIFT: begin
        // Even half-periods are SCLK-high; their end is a falling edge.
        if (tick_c) begin
          if (edge_cnt_q == EDGE_W'(31)) begin
            state_d = HOLD;
            sclk_d  = 1'b0;
          end else begin
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
            sclk_d     = ~sclk_q;
            if (!edge_cnt_q[0] && (edge_cnt_q != EDGE_W'(30))) begin
              shift_d = {shift_q[FRAME_W-2:0], 1'b0};
              copi_d  = shift_q[FRAME_W-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          state_d    = GAP;
          ncs_d      = 1'b1;
          copi_d     = 1'b0;
          gap_half_d = 1'b0;
        end
      end
      GAP: begin
        // Leave one cycle early so the IDLE/done cycle closes the 2H gap.
        if (tick_c) begin
          gap_half_d = 1'b1;
        end
        if (gap_half_q && pre_tick_c) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        ncs_d       = 1'b1;
        sclk_d      = 1'b0;
        copi_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase

    busy_d = ~cmd_ready_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      edge_cnt_q  <= '0;
      gap_half_q  <= 1'b0;
      ncs_q       <= 1'b1;
      sclk_q      <= 1'b0;
      copi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      edge_cnt_q  <= edge_cnt_d;
      gap_half_q  <= gap_half_d;
      ncs_q       <= ncs_d;
      sclk_q      <= sclk_d;
      copi_q      <= copi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ncs       = ncs_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;

endmodule

// File: tb/tb_spi_reg_write_initiator.sv
// Directed bench: SPI sniffers on a CLK_DIV=4 and a CLK_DIV=2 initiator check
// frame contents, chip-select/done timing, back-to-back, busy-drop and reset.
module tb_spi_reg_write_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid4, cmd_valid2;
  logic [6:0] cmd_addr4, cmd_addr2;
  logic [7:0] cmd_data4, cmd_data2;
  logic       cmd_ready4, busy4, done4, ncs4, sclk4, copi4;
  logic       cmd_ready2, busy2, done2, ncs2, sclk2, copi2;

  always #5 clk = ~clk;

  spi_reg_write_initiator #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_addr(cmd_addr4), .cmd_data(cmd_data4), .busy(busy4), .done(done4),
    .ncs(ncs4), .sclk(sclk4), .copi(copi4));

  spi_reg_write_initiator #(.CLK_DIV(2), .ADDR_W(7), .DATA_W(8)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_addr(cmd_addr2), .cmd_data(cmd_data2), .busy(busy2), .done(done2),
    .ncs(ncs2), .sclk(sclk2), .copi(copi2));

  int n_assert = 0;
  int n_fail   = 0;

  // SPI sniffers: shift on SCLK rise while selected, log frame on NCS rise.
  logic [15:0] sh4 = '0, sh2 = '0;
  int          rises4 = 0, rises2 = 0;
  logic [15:0] flog4 [32];
  logic [15:0] flog2 [32];
  int          rlog4 [32];
  int          rlog2 [32];
  int          frames4 = 0, frames2 = 0;
  int          dones4 = 0, dones2 = 0;
  longint      t_rise4 = -1;
  int          last_gap4 = 0;

  always @(posedge sclk4 or negedge ncs4)
    if (sclk4) begin
      if (!ncs4) begin sh4 = {sh4[14:0], copi4}; rises4++; end
    end else begin
      sh4 = '0; rises4 = 0;
    end

  always @(posedge sclk2 or negedge ncs2)
    if (sclk2) begin
      if (!ncs2) begin sh2 = {sh2[14:0], copi2}; rises2++; end
    end else begin
      sh2 = '0; rises2 = 0;
    end

  always @(posedge ncs4) begin
    t_rise4 = longint'($time);
    if (rises4 != 0 && frames4 < 32) begin
      flog4[frames4] = sh4; rlog4[frames4] = rises4; frames4++;
    end
  end

  always @(negedge ncs4)
    if (t_rise4 >= 0) last_gap4 = int'((longint'($time) - t_rise4) / 10);

  always @(posedge ncs2)
    if (rises2 != 0 && frames2 < 32) begin
      flog2[frames2] = sh2; rlog2[frames2] = rises2; frames2++;
    end

  always @(negedge clk) begin
    if (done4 === 1'b1) dones4++;
    if (done2 === 1'b1) dones2++;
  end

  // CLK_DIV=2 waveform monitor: copi must not move while sclk is high or at a rise.
  logic sclk2_p = 1'b0, copi2_p = 1'b0, seen_rise2 = 1'b0;
  int   run2 = 0, copi_viol2 = 0, bad_run2 = 0, hi_runs2 = 0;

  always @(negedge clk) begin
    if (ncs2 === 1'b0) begin
      if (sclk2 && (copi2 != copi2_p)) copi_viol2++;
      if (sclk2 == sclk2_p) run2++;
      else begin
        if (sclk2_p) begin hi_runs2++; if (run2 != 2) bad_run2++; end
        else if (seen_rise2 && run2 != 2) bad_run2++;
        if (sclk2) seen_rise2 = 1'b1;
        run2 = 1;
      end
    end else begin
      seen_rise2 = 1'b0; run2 = 0;
    end
    sclk2_p = sclk2; copi2_p = copi2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send4(input logic [6:0] a, input logic [7:0] d);
    cmd_valid4 = 1'b1; cmd_addr4 = a; cmd_data4 = d;
    @(negedge clk);
    cmd_valid4 = 1'b0;
  endtask

  task automatic send2(input logic [6:0] a, input logic [7:0] d);
    cmd_valid2 = 1'b1; cmd_addr2 = a; cmd_data2 = d;
    @(negedge clk);
    cmd_valid2 = 1'b0;
  endtask

  // Called on cycle 1 after the accept edge; counts ncs-low cycles and first done cycle.
  task automatic observe(input bit use2, input int n, output int ncs_low, output int done_at);
    ncs_low = 0; done_at = 0;
    for (int k = 1; k <= n; k++) begin
      if ((use2 ? ncs2 : ncs4) === 1'b0) ncs_low++;
      if ((use2 ? done2 : done4) === 1'b1 && done_at == 0) done_at = k;
      @(negedge clk);
    end
  endtask

  int f0, d0, nl, da, acc_at, v0, b0, h0;

  initial begin
    rst = 1'b1;
    cmd_valid4 = 1'b0; cmd_addr4 = '0; cmd_data4 = '0;
    cmd_valid2 = 1'b0; cmd_addr2 = '0; cmd_data2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ncs", 32'(ncs4), 32'd1);
    chk("rst_sclk", 32'(sclk4), 32'd0);
    chk("rst_ready", 32'(cmd_ready4), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ncs4", 32'(ncs4), 32'd1);
    chk("idle_copi4", 32'(copi4), 32'd0);
    chk("idle_busy4", 32'(busy4), 32'd0);
    chk("idle_done4", 32'(done4), 32'd0);
    chk("idle_ncs2", 32'(ncs2), 32'd1);
    chk("idle_ready2", 32'(cmd_ready2), 32'd1);

    // 1: single frame 0x04/0x80
    f0 = frames4; d0 = dones4;
    chk("t1_ready_pre", 32'(cmd_ready4), 32'd1);
    send4(7'h04, 8'h80);
    chk("t1_ready_busy", 32'(cmd_ready4), 32'd0);
    chk("t1_busy", 32'(busy4), 32'd1);
    observe(1'b0, 160, nl, da);
    chk("t1_ncs_low", 32'(nl), 32'd136);
    chk("t1_done_cycle", 32'(da), 32'd144);
    chk("t1_frames", 32'(frames4 - f0), 32'd1);
    chk("t1_frame", 32'(flog4[f0]), 32'h8480);
    chk("t1_rises", 32'(rlog4[f0]), 32'd16);
    chk("t1_dones", 32'(dones4 - d0), 32'd1);

    // 2: back-to-back with cmd_valid held; second command staged while busy
    f0 = frames4; d0 = dones4;
    send4(7'h00, 8'hFF);
    cmd_valid4 = 1'b1; cmd_addr4 = 7'h02; cmd_data4 = 8'h0F;
    acc_at = 0;
    for (int k = 1; k <= 300 && acc_at == 0; k++) begin
      if (cmd_ready4 === 1'b1) acc_at = k;
      @(negedge clk);
    end
    cmd_valid4 = 1'b0;
    chk("t2_next_accept", 32'(acc_at), 32'd144);
    repeat (160) @(negedge clk);
    chk("t2_frames", 32'(frames4 - f0), 32'd2);
    chk("t2_frame_a", 32'(flog4[f0]), 32'h80FF);
    chk("t2_frame_b", 32'(flog4[f0 + 1]), 32'h820F);
    chk("t2_gap", 32'(last_gap4), 32'd8);
    chk("t2_dones", 32'(dones4 - d0), 32'd2);

    // 3: command offered mid-frame is dropped
    f0 = frames4; d0 = dones4;
    send4(7'h03, 8'h3C);
    repeat (40) @(negedge clk);
    cmd_valid4 = 1'b1; cmd_addr4 = 7'h01; cmd_data4 = 8'h33;
    chk("t3_ready_mid", 32'(cmd_ready4), 32'd0);
    @(negedge clk);
    cmd_valid4 = 1'b0;
    chk("t3_busy_mid", 32'(busy4), 32'd1);
    repeat (250) @(negedge clk);
    chk("t3_frames", 32'(frames4 - f0), 32'd1);
    chk("t3_frame", 32'(flog4[f0]), 32'h833C);
    chk("t3_dones", 32'(dones4 - d0), 32'd1);
    chk("t3_ready_end", 32'(cmd_ready4), 32'd1);

    // 4: reset after the 7th sclk rise, then a clean frame
    d0 = dones4;
    send4(7'h03, 8'hAA);
    for (int k = 0; k < 100 && rises4 < 7; k++) @(negedge clk);
    chk("t4_rises_before_rst", 32'(rises4), 32'd7);
    chk("t4_copi_before_rst", 32'(copi4), 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_ncs", 32'(ncs4), 32'd1);
    chk("t4_sclk", 32'(sclk4), 32'd0);
    chk("t4_copi", 32'(copi4), 32'd0);
    chk("t4_ready", 32'(cmd_ready4), 32'd1);
    chk("t4_busy", 32'(busy4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("t4_no_done", 32'(dones4 - d0), 32'd0);
    chk("t4_trunc_rises", 32'(rlog4[frames4 - 1]), 32'd7);
    f0 = frames4; d0 = dones4;
    send4(7'h02, 8'h0F);
    observe(1'b0, 160, nl, da);
    chk("t4_post_frames", 32'(frames4 - f0), 32'd1);
    chk("t4_post_frame", 32'(flog4[f0]), 32'h820F);
    chk("t4_post_rises", 32'(rlog4[f0]), 32'd16);
    chk("t4_post_done", 32'(da), 32'd144);

    // 5: CLK_DIV=2, copi stability and sclk half-periods
    f0 = frames2; d0 = dones2; v0 = copi_viol2; b0 = bad_run2; h0 = hi_runs2;
    chk("t5_ready_pre", 32'(cmd_ready2), 32'd1);
    send2(7'h02, 8'hA5);
    observe(1'b1, 90, nl, da);
    chk("t5_ncs_low", 32'(nl), 32'd68);
    chk("t5_done_cycle", 32'(da), 32'd72);
    chk("t5_frames", 32'(frames2 - f0), 32'd1);
    chk("t5_frame", 32'(flog2[f0]), 32'h82A5);
    chk("t5_rises", 32'(rlog2[f0]), 32'd16);
    chk("t5_copi_stable", 32'(copi_viol2 - v0), 32'd0);
    chk("t5_bad_runs", 32'(bad_run2 - b0), 32'd0);
    chk("t5_high_runs", 32'(hi_runs2 - h0), 32'd16);
    chk("t5_dones", 32'(dones2 - d0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
